// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state encoding
// and the default operand width.
package cmp_pkg;

  localparam int CMP_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/OneBitComparator.sv
// Single-bit magnitude comparison cell; purely combinational, outputs one-hot.
module OneBitComparator (
  input  logic a,
  input  logic b,
  output logic g,
  output logic e,
  output logic l
);

  assign g = a & ~b;
  assign e = ~(a ^ b);
  assign l = ~a & b;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial WIDTH-bit magnitude comparator: walks operands MSB first through
// one OneBitComparator cell and stops at the first differing bit pair.
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = CMP_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             e,
  output logic             l
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   sa_reg, sa_next;
  logic [WIDTH-1:0]   sb_reg, sb_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               g_reg, g_next;
  logic               e_reg, e_next;
  logic               l_reg, l_next;
  logic               bit_g, bit_e, bit_l;

  OneBitComparator u_bit_cmp (
    .g (bit_g),
    .e (bit_e),
    .l (bit_l),
    .a (sa_reg[WIDTH-1]),
    .b (sb_reg[WIDTH-1])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sa_reg    <= '0;
      sb_reg    <= '0;
      cnt_reg   <= '0;
      g_reg     <= 1'b0;
      e_reg     <= 1'b0;
      l_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      sa_reg    <= sa_next;
      sb_reg    <= sb_next;
      cnt_reg   <= cnt_next;
      g_reg     <= g_next;
      e_reg     <= e_next;
      l_reg     <= l_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sa_next    = sa_reg;
    sb_next    = sb_reg;
    cnt_next   = cnt_reg;
    g_next     = g_reg;
    e_next     = e_reg;
    l_next     = l_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          sa_next    = a;
          sb_next    = b;
          cnt_next   = CNT_W'(WIDTH);
          g_next     = 1'b0;
          e_next     = 1'b0;
          l_next     = 1'b0;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end

      SHIFT: begin
        if (bit_g || bit_l) begin
          // First differing bit decides the whole comparison.
          g_next     = bit_g;
          l_next     = bit_l;
          e_next     = 1'b0;
          state_next = DONE;
        end else if (cnt_reg == CNT_W'(1)) begin
          g_next     = 1'b0;
          l_next     = 1'b0;
          e_next     = bit_e;
          state_next = DONE;
        end else begin
          sa_next  = sa_reg << 1;
          sb_next  = sb_reg << 1;
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg == SHIFT);
  assign done = (state_reg == DONE);
  assign g    = g_reg;
  assign e    = e_reg;
  assign l    = l_reg;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed, table-driven bench for serial_magnitude_comparator at WIDTH=8.
module tb_serial_magnitude_comparator;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic         g;
  logic         e;
  logic         l;

  int total = 0;
  int bad   = 0;

  serial_magnitude_comparator #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a_in),
    .b     (b_in),
    .busy  (busy),
    .done  (done),
    .g     (g),
    .e     (e),
    .l     (l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    int         k;
    logic [2:0] gel;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
    end else begin
      $display("ok   %s: %0d", nm, got);
    end
  endtask

  // Caller must be at a falling edge; returns 1 time unit after the accepting edge.
  task automatic launch(input logic [7:0] av, input logic [7:0] bv);
    a_in  = av;
    b_in  = bv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns at the falling edge where done is high (or after the cycle budget).
  task automatic run_check(input string nm, input int k, input logic [2:0] gel);
    int lat;
    int nbusy;
    lat   = -1;
    nbusy = 0;
    for (int j = 0; j <= W + 2; j++) begin
      @(negedge clk);
      if (done) begin
        lat = j;
        break;
      end
      if (busy) nbusy++;
    end
    chk({nm, " latency"}, lat, k);
    chk({nm, " busy_cycles"}, nbusy, k);
    chk({nm, " gel"}, int'({g, e, l}), int'(gel));
    chk({nm, " busy_in_done"}, int'(busy), 0);
  endtask

  initial begin
    vecs[0] = '{"gt_msb",   8'h80, 8'h7F, 1, 3'b100};
    vecs[1] = '{"eq_5a",    8'h5A, 8'h5A, 8, 3'b010};
    vecs[2] = '{"lt_lsb",   8'h12, 8'h13, 8, 3'b001};
    vecs[3] = '{"gt_ff00",  8'hFF, 8'h00, 1, 3'b100};
    vecs[4] = '{"lt_0001",  8'h00, 8'h01, 8, 3'b001};
    vecs[5] = '{"lt_7fff",  8'h7F, 8'hFF, 1, 3'b001};
    vecs[6] = '{"gt_lsb",   8'hA5, 8'hA4, 8, 3'b100};
    vecs[7] = '{"lt_bit2",  8'h33, 8'h37, 6, 3'b001};

    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    #3;
    chk("reset outputs", int'({busy, done, g, e, l}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      launch(vecs[i].a, vecs[i].b);
      run_check(vecs[i].name, vecs[i].k, vecs[i].gel);
      @(negedge clk);
      chk({vecs[i].name, " done_one_cycle"}, int'(done), 0);
      repeat (5) @(negedge clk);
      chk({vecs[i].name, " held"}, int'({g, e, l}), int'(vecs[i].gel));
    end

    // start during SHIFT must be ignored
    @(negedge clk);
    launch(8'hF0, 8'hE0);
    @(negedge clk);
    a_in  = 8'h00;
    b_in  = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    begin
      int lat;
      lat = -1;
      for (int j = 1; j <= W + 2; j++) begin
        @(negedge clk);
        if (done) begin
          lat = j;
          break;
        end
      end
      chk("ignore_start latency", lat, 4);
      chk("ignore_start gel", int'({g, e, l}), int'(3'b100));
    end
    @(negedge clk);
    chk("ignore_start idle_after", int'({busy, done}), 0);

    // asynchronous reset mid-SHIFT aborts without a done pulse
    @(negedge clk);
    launch(8'h01, 8'h02);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort outputs_zero", int'({busy, done, g, e, l}), 0);
    #1 rst_n = 1'b1;
    begin
      int ndone;
      ndone = 0;
      for (int j = 0; j < W + 4; j++) begin
        @(negedge clk);
        if (done) ndone++;
      end
      chk("abort no_done", ndone, 0);
    end
    @(negedge clk);
    launch(8'h03, 8'h03);
    run_check("after_abort eq", 8, 3'b010);

    // back-to-back: second start accepted from the DONE cycle
    @(negedge clk);
    @(negedge clk);
    launch(8'h40, 8'h00);
    run_check("b2b first", 2, 3'b100);
    launch(8'h00, 8'h40);
    chk("b2b cleared", int'({g, e, l}), 0);
    chk("b2b busy", int'({busy, done}), 2);
    begin
      int lat;
      lat = -1;
      for (int j = 0; j <= W + 2; j++) begin
        @(negedge clk);
        if (done) begin
          lat = j;
          break;
        end
      end
      chk("b2b second latency", lat, 2);
      chk("b2b second gel", int'({g, e, l}), int'(3'b001));
    end
    @(negedge clk);
    chk("b2b done_one_cycle", int'(done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
